// File: rtl/_univ_shift_reg_rs.sv
// Universal WIDTH-bit shift register with synchronous active-low reset and set.
// A command can load, clear, or shift/rotate the register by amt bits, one bit per clock.
module _univ_shift_reg_rs #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             set_n,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] d,
  input  logic             si,
  output logic [WIDTH-1:0] q,
  output logic             so,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] M_LOAD = 3'b000;
  localparam logic [2:0] M_SHL  = 3'b001;
  localparam logic [2:0] M_SHR  = 3'b010;
  localparam logic [2:0] M_ROL  = 3'b011;
  localparam logic [2:0] M_ROR  = 3'b100;
  localparam logic [2:0] M_ASR  = 3'b101;
  localparam logic [2:0] M_CLR  = 3'b110;
  localparam logic [2:0] M_RSV  = 3'b111;

  localparam logic [AMT_W-1:0] CNT_ONE = AMT_W'(1);

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_nxt;
  logic             r_so;
  logic             w_so_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic [AMT_W-1:0] r_cnt;
  logic [AMT_W-1:0] w_cnt_nxt;
  logic [2:0]       r_mode;
  logic [2:0]       w_mode_nxt;

  // One-bit step of the register contents for a latched shift mode.
  function automatic logic [WIDTH-1:0] step_q(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] v,
    input logic             s
  );
    case (m)
      M_SHL:   return {v[WIDTH-2:0], s};
      M_SHR:   return {s, v[WIDTH-1:1]};
      M_ROL:   return {v[WIDTH-2:0], v[WIDTH-1]};
      M_ROR:   return {v[0], v[WIDTH-1:1]};
      M_ASR:   return {v[WIDTH-1], v[WIDTH-1:1]};
      default: return v;
    endcase
  endfunction

  // Bit leaving the register on the same step: the MSB for left moves, the LSB otherwise.
  function automatic logic step_so(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] v
  );
    case (m)
      M_SHL, M_ROL: return v[WIDTH-1];
      default:      return v[0];
    endcase
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_so_nxt    = r_so;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_cnt_nxt   = r_cnt;
    w_mode_nxt  = r_mode;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_mode_nxt = mode;
          case (mode)
            M_LOAD: begin
              w_q_nxt    = d;
              w_done_nxt = 1'b1;
            end
            M_CLR: begin
              w_q_nxt    = '0;
              w_done_nxt = 1'b1;
            end
            M_RSV: begin
            end
            default: begin
              if (amt == '0) begin
                w_done_nxt = 1'b1;
              end else begin
                w_busy_nxt  = 1'b1;
                w_cnt_nxt   = amt;
                w_state_nxt = ST_SHIFT;
              end
            end
          endcase
        end
      end
      ST_SHIFT: begin
        w_q_nxt   = step_q(r_mode, r_q, si);
        w_so_nxt  = step_so(r_mode, r_q);
        w_cnt_nxt = r_cnt - CNT_ONE;
        // The edge that consumes the last count also finishes the command.
        if (r_cnt == CNT_ONE) begin
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_q     <= '0;
      r_so    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_mode  <= M_LOAD;
    end else if (!set_n) begin
      r_state <= ST_IDLE;
      r_q     <= '1;
      r_so    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_so    <= w_so_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mode  <= w_mode_nxt;
    end
  end

  assign q    = r_q;
  assign so   = r_so;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb__univ_shift_reg_rs.sv
// Directed bench for _univ_shift_reg_rs: reset/set priority, load, shifts, rotates,
// zero-amount, ignored start, aborts and back-to-back commands.
module tb__univ_shift_reg_rs;

  logic       clk;
  logic       reset_n;
  logic       set_n;
  logic       start;
  logic [2:0] mode;
  logic [2:0] amt;
  logic [7:0] d;
  logic       si;
  logic [7:0] q;
  logic       so;
  logic       busy;
  logic       done;

  int total;
  int bad;

  _univ_shift_reg_rs #(.WIDTH(8), .AMT_W(3)) dut (
    .clk(clk), .reset_n(reset_n), .set_n(set_n), .start(start), .mode(mode),
    .amt(amt), .d(d), .si(si), .q(q), .so(so), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [2:0] m, input logic [2:0] a, input logic [7:0] dd);
    start = 1'b1; mode = m; amt = a; d = dd;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; set_n = 1'b0;
    tick(); tick();
    total++; if (q !== 8'h00) begin bad++; $display("FAIL reset_q got=%h exp=00", q); end
    total++; if (busy !== 1'b0 || done !== 1'b0 || so !== 1'b0) begin bad++; $display("FAIL reset_flags got busy=%b done=%b so=%b exp 000", busy, done, so); end
    reset_n = 1'b1;
    tick();
    total++; if (q !== 8'hFF) begin bad++; $display("FAIL set_q got=%h exp=FF", q); end
    set_n = 1'b1;
    tick();
    total++; if (q !== 8'hFF || done !== 1'b0) begin bad++; $display("FAIL set_hold got q=%h done=%b exp FF 0", q, done); end
  endtask

  task automatic test_load_shl();
    cmd(3'b000, 3'd0, 8'h81);
    total++; if (q !== 8'h81 || done !== 1'b1) begin bad++; $display("FAIL load got q=%h done=%b exp 81 1", q, done); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL load_done_pulse got=%b exp=0", done); end
    si = 1'b1;
    cmd(3'b001, 3'd3, 8'h00);
    total++; if (q !== 8'h81 || busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL shl_k0 got q=%h busy=%b done=%b exp 81 1 0", q, busy, done); end
    tick();
    total++; if (q !== 8'h03 || busy !== 1'b1 || so !== 1'b1) begin bad++; $display("FAIL shl_1 got q=%h busy=%b so=%b exp 03 1 1", q, busy, so); end
    tick();
    total++; if (q !== 8'h07 || busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL shl_2 got q=%h busy=%b done=%b exp 07 1 0", q, busy, done); end
    tick();
    total++; if (q !== 8'h0F || busy !== 1'b0 || done !== 1'b1 || so !== 1'b0) begin bad++; $display("FAIL shl_3 got q=%h busy=%b done=%b so=%b exp 0F 0 1 0", q, busy, done, so); end
    tick();
    total++; if (done !== 1'b0 || q !== 8'h0F) begin bad++; $display("FAIL shl_after got q=%h done=%b exp 0F 0", q, done); end
    si = 1'b0;
  endtask

  task automatic test_rotate_asr();
    cmd(3'b000, 3'd0, 8'hA5);
    cmd(3'b100, 3'd3, 8'h00);
    tick();
    total++; if (q !== 8'hD2 || so !== 1'b1) begin bad++; $display("FAIL ror_1 got q=%h so=%b exp D2 1", q, so); end
    tick();
    total++; if (q !== 8'h69 || so !== 1'b0) begin bad++; $display("FAIL ror_2 got q=%h so=%b exp 69 0", q, so); end
    tick();
    total++; if (q !== 8'hB4 || so !== 1'b1 || done !== 1'b1) begin bad++; $display("FAIL ror_3 got q=%h so=%b done=%b exp B4 1 1", q, so, done); end
    cmd(3'b000, 3'd0, 8'h90);
    total++; if (so !== 1'b1) begin bad++; $display("FAIL load_keeps_so got=%b exp=1", so); end
    cmd(3'b101, 3'd2, 8'h00);
    tick();
    total++; if (q !== 8'hC8 || so !== 1'b0) begin bad++; $display("FAIL asr_1 got q=%h so=%b exp C8 0", q, so); end
    tick();
    total++; if (q !== 8'hE4 || so !== 1'b0 || done !== 1'b1) begin bad++; $display("FAIL asr_2 got q=%h so=%b done=%b exp E4 0 1", q, so, done); end
  endtask

  task automatic test_zero_and_ignored();
    cmd(3'b000, 3'd0, 8'h3C);
    cmd(3'b001, 3'd0, 8'h00);
    total++; if (q !== 8'h3C || done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL zero_amt got q=%h done=%b busy=%b exp 3C 1 0", q, done, busy); end
    tick();
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL zero_after got busy=%b done=%b exp 0 0", busy, done); end
    cmd(3'b111, 3'd0, 8'h55);
    total++; if (q !== 8'h3C || done !== 1'b0) begin bad++; $display("FAIL reserved got q=%h done=%b exp 3C 0", q, done); end
    cmd(3'b000, 3'd0, 8'h01);
    cmd(3'b011, 3'd4, 8'h00);
    cmd(3'b000, 3'd0, 8'hFF);
    total++; if (q !== 8'h02 || busy !== 1'b1) begin bad++; $display("FAIL rol_ignore got q=%h busy=%b exp 02 1", q, busy); end
    tick(); tick();
    total++; if (q !== 8'h08 || done !== 1'b0) begin bad++; $display("FAIL rol_3 got q=%h done=%b exp 08 0", q, done); end
    tick();
    total++; if (q !== 8'h10 || done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rol_4 got q=%h done=%b busy=%b exp 10 1 0", q, done, busy); end
  endtask

  task automatic test_abort();
    cmd(3'b000, 3'd0, 8'hF0);
    si = 1'b0;
    cmd(3'b010, 3'd5, 8'h00);
    tick();
    total++; if (q !== 8'h78 || busy !== 1'b1) begin bad++; $display("FAIL shr_1 got q=%h busy=%b exp 78 1", q, busy); end
    set_n = 1'b0;
    tick();
    set_n = 1'b1;
    total++; if (q !== 8'hFF || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL set_abort got q=%h busy=%b done=%b exp FF 0 0", q, busy, done); end
    tick(); tick();
    total++; if (q !== 8'hFF || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL set_abort_idle got q=%h busy=%b done=%b exp FF 0 0", q, busy, done); end
    cmd(3'b000, 3'd0, 8'hF1);
    si = 1'b1;
    cmd(3'b010, 3'd5, 8'h00);
    tick();
    total++; if (q !== 8'hF8 || so !== 1'b1) begin bad++; $display("FAIL shr_si got q=%h so=%b exp F8 1", q, so); end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    si = 1'b0;
    total++; if (q !== 8'h00 || so !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_abort got q=%h so=%b busy=%b done=%b exp 00 0 0 0", q, so, busy, done); end
    tick(); tick();
    total++; if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_abort_idle got q=%h busy=%b done=%b exp 00 0 0", q, busy, done); end
  endtask

  task automatic test_back_to_back();
    start = 1'b1; mode = 3'b000; d = 8'h5A; amt = 3'd0;
    tick();
    total++; if (q !== 8'h5A || done !== 1'b1) begin bad++; $display("FAIL b2b_load got q=%h done=%b exp 5A 1", q, done); end
    mode = 3'b110;
    tick();
    start = 1'b0;
    total++; if (q !== 8'h00 || done !== 1'b1) begin bad++; $display("FAIL b2b_clr got q=%h done=%b exp 00 1", q, done); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL b2b_end got done=%b exp 0", done); end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    total = 0; bad = 0;
    reset_n = 1'b0; set_n = 1'b1; start = 1'b0; mode = 3'b000;
    amt = 3'd0; d = 8'h00; si = 1'b0;
    #1;
    test_reset();
    test_load_shl();
    test_rotate_asr();
    test_zero_and_ignored();
    test_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/_univ_shift_reg_rs.md
Name: _univ_shift_reg_rs

Overview:
Parametrised universal shift register with synchronous active-low set and reset. Each start command either loads or clears the register in one cycle, or performs a multi-bit shift/rotate one bit per clock, with busy/done status. It generalises the single-bit set/reset flip-flop into a WIDTH-bit datapath storage/serialisation element.

Parameters:
WIDTH, 8, register width in bits (>= 2)
AMT_W, 3, width of shift-amount input; amt ranges 0..2^AMT_W-1 (amt >= WIDTH is legal and shifts that many bits)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  synchronous active-low reset; sampled only on rising clk
set_n  input  1  synchronous active-low set, forces q to all ones
start  input  1  command strobe, sampled only when idle
mode  input  3  operation select, sampled with start
amt  input  AMT_W  shift count, sampled with start
d  input  WIDTH  parallel load data, sampled with start
si  input  1  serial in, sampled at every shift edge
q  output  WIDTH  register contents
so  output  1  registered copy of last bit shifted out
busy  output  1  high while a multi-cycle shift is in progress
done  output  1  one-cycle pulse on command completion

Behaviour:
- One clock, clk. reset_n is synchronous and active-low; every state change happens on rising clk.
- Priority at each edge: reset_n low > set_n low > command logic.
- reset_n low: q=0, so=0, busy=0, done=0, FSM=IDLE, internal count=0.
- set_n low (reset_n high): q={WIDTH{1}}, so=0, busy=0, done=0, FSM=IDLE. Aborts any shift in progress.
- done defaults to 0 every edge unless set as below.
- FSM states: IDLE, SHIFT.
- IDLE with start=1 at edge k0: latch mode and amt.
  - 000 LOAD: q<=d; done=1.
  - 110 CLR: q<=0; done=1.
  - 111 reserved: no change; no done.
  - Shift modes 001 SHL, 010 SHR, 011 ROL, 100 ROR, 101 ASR:
    - amt=0: q unchanged; done=1; stay IDLE.
    - amt=N>0: busy<=1; cnt<=N; go to SHIFT. q is unchanged at k0.
- SHIFT, each edge: apply one bit step to q; cnt<=cnt-1.
  - SHL: q<={q[W-2:0],si}; so<=q[W-1].
  - SHR: q<={si,q[W-1:1]}; so<=q[0].
  - ROL: q<={q[W-2:0],q[W-1]}; so<=q[W-1].
  - ROR: q<={q[0],q[W-1:1]}; so<=q[0].
  - ASR: q<={q[W-1],q[W-1:1]}; so<=q[0].
  - The edge where cnt=1 applies the final step. At that same edge: busy<=0, done<=1, FSM=IDLE.
  - Timing: for an N-bit shift, done is first seen after edge k0+N; busy is high for N cycles.
- start is ignored while busy. d, mode and amt are ignored except at the accepting edge.
- start may be reasserted in the cycle done is high; it is accepted, giving back-to-back commands.
- so changes only on shift steps; load and clear leave it unchanged.

Test Plan:
- Priority: reset_n=0 and set_n=0 together for 2 edges -> q=00, busy=0, done=0. Then reset_n=1, set_n=0 -> q=FF next edge.
- Load and SHL: LOAD d=81 -> q=81, done 1 cycle. Then SHL amt=3 with si=1 -> q=03, 07, 0F on successive edges; busy high 3 cycles; done with q=0F; so=0.
- Rotate and arithmetic shift: LOAD A5, ROR amt=3 -> q=D2, 69, B4; so=1 at end. LOAD 90, ASR amt=2 -> q=C8, E4; so=0.
- Zero amount and ignored start: SHL amt=0 on q=3C -> done next edge, q=3C, busy never high. During a ROL amt=4 on 01, pulse start with LOAD d=FF -> ignored; final q=10.
- Abort mid-shift: SHR amt=5 on q=F0; set_n=0 on the 2nd shift edge -> q=FF, busy=0, no done. Repeat with reset_n=0 -> q=00, so=0.
- Back-to-back commands: start held high through done with LOAD d=5A then CLR -> q=5A then 00, two done pulses on consecutive edges.
